// File: rtl/shift_reg_ctrl.sv
// Parallel-to-serial sequencer feeding the serial shift register's data_in.
// Optional trailing even-parity bit: define SHIFT_REG_PARITY_EN.
module shift_reg_ctrl #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         flush,
    output logic                         shift_en,
    output logic                         data_out,
    output logic                         busy,
    output logic                         frame_start,
    output logic                         frame_done,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [7:0]    GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
`ifdef SHIFT_REG_PARITY_EN
        PAR   = 3'd2,
`endif
        DONE  = 3'd3,
        GAPW  = 3'd4
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] word;
    logic [7:0]       gap_cnt;

    // Bit idx of the frame, counted in transmission order.
    function automatic logic pick(input logic [WIDTH-1:0] w, input logic [CW-1:0] idx);
        logic [WIDTH-1:0] s;
        if (MSB_FIRST) begin
            s    = w << idx;
            pick = s[WIDTH-1];
        end else begin
            s    = w >> idx;
            pick = s[0];
        end
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            word        <= '0;
            gap_cnt     <= '0;
            in_ready    <= 1'b0;
            shift_en    <= 1'b0;
            data_out    <= 1'b0;
            busy        <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            bit_cnt     <= '0;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            if (flush && state != IDLE) begin
                // Abort: in_ready comes back on the following edge from IDLE.
                state    <= IDLE;
                gap_cnt  <= '0;
                in_ready <= 1'b0;
                busy     <= 1'b0;
                shift_en <= 1'b0;
                data_out <= 1'b0;
                bit_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid && in_ready && !flush) begin
                            word        <= in_data;
                            state       <= SHIFT;
                            in_ready    <= 1'b0;
                            busy        <= 1'b1;
                            shift_en    <= 1'b1;
                            frame_start <= 1'b1;
                            bit_cnt     <= '0;
                            data_out    <= pick(in_data, '0);
                        end else begin
                            in_ready <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (bit_cnt == LAST_IDX) begin
`ifdef SHIFT_REG_PARITY_EN
                            state    <= PAR;
                            bit_cnt  <= CW'(WIDTH);
                            data_out <= ^word;
`else
                            state      <= DONE;
                            shift_en   <= 1'b0;
                            data_out   <= 1'b0;
                            bit_cnt    <= '0;
                            frame_done <= 1'b1;
`endif
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            data_out <= pick(word, bit_cnt + 1'b1);
                        end
                    end
`ifdef SHIFT_REG_PARITY_EN
                    PAR: begin
                        state      <= DONE;
                        shift_en   <= 1'b0;
                        data_out   <= 1'b0;
                        bit_cnt    <= '0;
                        frame_done <= 1'b1;
                    end
`endif
                    DONE: begin
                        if (GAP > 0) begin
                            state   <= GAPW;
                            gap_cnt <= GAP_LAST;
                        end else begin
                            state    <= IDLE;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end
                    GAPW: begin
                        if (gap_cnt == 8'd0) begin
                            state    <= IDLE;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt - 8'd1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        shift_en <= 1'b0;
                        data_out <= 1'b0;
                        bit_cnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Scoreboard bench for shift_reg_ctrl: lane 0 is MSB-first/GAP=0, lane 1 is LSB-first/GAP=3.
module tb_shift_reg_ctrl;

    localparam int WIDTH = 8;
`ifdef SHIFT_REG_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NF = WIDTH + PAR;

    typedef struct {
        logic [WIDTH:0] bits;   // expected serial stream, first bit in bit 0
        int             nbits;  // bits expected before shift_en drops
        bit             done;   // frame_done expected when shift_en drops
        bit             b2b;    // frame_start spacing from previous frame is checked
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   go     = 1'b0;
    bit   go2    = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ir, input logic se, input logic dd,
                            input logic bz, input logic fs, input logic fd, input logic [3:0] bc);
        chk({tag, "_in_ready"}, int'(ir), 0);
        chk({tag, "_shift_en"}, int'(se), 0);
        chk({tag, "_data_out"}, int'(dd), 0);
        chk({tag, "_busy"}, int'(bz), 0);
        chk({tag, "_frame_start"}, int'(fs), 0);
        chk({tag, "_frame_done"}, int'(fd), 0);
        chk({tag, "_bit_cnt"}, int'(bc), 0);
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam bit MSBF   = (g == 0);
        localparam int GAPV   = (g == 0) ? 0 : 3;
        localparam int PERIOD = WIDTH + 2 + PAR + GAPV;

        logic             in_valid;
        logic             in_ready;
        logic [WIDTH-1:0] in_data;
        logic             flush;
        logic             shift_en;
        logic             data_out;
        logic             busy;
        logic             frame_start;
        logic             frame_done;
        logic [3:0]       bit_cnt;

        shift_reg_ctrl #(.WIDTH(WIDTH), .MSB_FIRST(MSBF), .GAP(GAPV)) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
            .in_data(in_data), .flush(flush), .shift_en(shift_en), .data_out(data_out),
            .busy(busy), .frame_start(frame_start), .frame_done(frame_done), .bit_cnt(bit_cnt)
        );

        exp_t sb[$];
        exp_t cur;
        bit   coll       = 1'b0;
        int   nb         = 0;
        int   last_start = 0;
        bit   done1      = 1'b0;
        bit   req_rst    = 1'b0;

        function automatic exp_t mk_exp(input logic [WIDTH-1:0] w, input int nbits,
                                        input bit dn, input bit b2b);
            exp_t             e;
            logic [WIDTH:0]   one;
            logic [WIDTH-1:0] t;
            int               pos;
            one    = 1;
            e.bits = '0;
            for (int i = 0; i < WIDTH; i++) begin
                pos = MSBF ? (WIDTH - 1 - i) : i;
                t   = w >> pos;
                if (t[0]) e.bits = e.bits | (one << i);
            end
            if (PAR != 0 && (^w)) e.bits = e.bits | (one << WIDTH);
            e.nbits = nbits;
            e.done  = dn;
            e.b2b   = b2b;
            return e;
        endfunction

        // Present a word and hold it until the next edge accepts it; returns at the
        // negedge before the accepting edge.
        task automatic offer(input logic [WIDTH-1:0] w, input int nbits, input bit dn, input bit b2b);
            in_valid = 1'b1;
            in_data  = w;
            for (int i = 0; i < 200 && !in_ready; i++) @(negedge clk);
            chk($sformatf("L%0d_accept_wait", g), int'(in_ready), 1);
            if (in_ready) sb.push_back(mk_exp(w, nbits, dn, b2b));
        endtask

        always @(negedge clk) begin
            if (!rst) begin
                if (coll) begin
                    chk($sformatf("L%0d_rst_abort_bits", g), nb, cur.nbits);
                    coll = 1'b0;
                end
            end else if (shift_en) begin
                if (!coll) begin
                    if (sb.size() == 0) begin
                        chk($sformatf("L%0d_unexpected_frame", g), 1, 0);
                        cur.bits = '0; cur.nbits = 0; cur.done = 1'b0; cur.b2b = 1'b0;
                    end else begin
                        cur = sb.pop_front();
                    end
                    coll = 1'b1;
                    nb   = 0;
                    chk($sformatf("L%0d_frame_start", g), int'(frame_start), 1);
                    if (cur.b2b) chk($sformatf("L%0d_start_spacing", g), cyc - last_start, PERIOD);
                    last_start = cyc;
                end else begin
                    chk($sformatf("L%0d_frame_start_extra", g), int'(frame_start), 0);
                end
                chk($sformatf("L%0d_data_bit%0d", g, nb), int'(data_out), int'(cur.bits[0]));
                chk($sformatf("L%0d_bit_cnt", g), int'(bit_cnt), nb);
                chk($sformatf("L%0d_busy_shift", g), int'(busy), 1);
                chk($sformatf("L%0d_ready_shift", g), int'(in_ready), 0);
                cur.bits = cur.bits >> 1;
                nb++;
            end else begin
                if (coll) begin
                    chk($sformatf("L%0d_frame_len", g), nb, cur.nbits);
                    chk($sformatf("L%0d_frame_done", g), int'(frame_done), int'(cur.done));
                    coll = 1'b0;
                end else begin
                    chk($sformatf("L%0d_stray_done", g), int'(frame_done), 0);
                end
                chk($sformatf("L%0d_idle_data", g), int'(data_out), 0);
                chk($sformatf("L%0d_idle_cnt", g), int'(bit_cnt), 0);
            end
        end

        initial begin
            logic [WIDTH-1:0] w;
            int               k;
            in_valid = 1'b0;
            in_data  = '0;
            flush    = 1'b0;
            wait (go);
            @(negedge clk);
            // Directed words
            offer(8'hA5, NF, 1'b1, 1'b0); @(negedge clk); in_valid = 1'b0;
            repeat (2) @(negedge clk);
            offer(8'h01, NF, 1'b1, 1'b0); @(negedge clk); in_valid = 1'b0;
            offer(8'h07, NF, 1'b1, 1'b0); @(negedge clk); in_valid = 1'b0;
            // Back-to-back with in_valid held
            offer(8'hFF, NF, 1'b1, 1'b0); @(negedge clk);
            offer(8'h00, NF, 1'b1, 1'b1); @(negedge clk); in_valid = 1'b0;
            // in_valid pulse and in_data change while busy
            offer(8'hA5, NF, 1'b1, 1'b0); @(negedge clk); in_valid = 1'b0;
            repeat (2) @(negedge clk);
            in_valid = 1'b1; in_data = 8'h3C;
            @(negedge clk);
            in_valid = 1'b0;
            // Flush after 3 bits
            offer(8'hA5, 3, 1'b0, 1'b0); @(negedge clk); in_valid = 1'b0;
            repeat (2) @(negedge clk);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            chk($sformatf("L%0d_flush_shift_en", g), int'(shift_en), 0);
            chk($sformatf("L%0d_flush_ready_early", g), int'(in_ready), 0);
            chk($sformatf("L%0d_flush_busy", g), int'(busy), 0);
            @(negedge clk);
            chk($sformatf("L%0d_flush_ready", g), int'(in_ready), 1);
            // Flush beats in_valid in IDLE
            in_valid = 1'b1; in_data = 8'h3C; flush = 1'b1;
            repeat (2) @(negedge clk);
            chk($sformatf("L%0d_flush_idle_busy", g), int'(busy), 0);
            chk($sformatf("L%0d_flush_idle_ready", g), int'(in_ready), 1);
            in_valid = 1'b0; flush = 1'b0;
            // Random words, some aborted by flush
            for (int n = 0; n < 12; n++) begin
                w = WIDTH'($urandom);
                if ($urandom_range(0, 2) == 0) begin
                    k = $urandom_range(1, WIDTH - 1);
                    offer(w, k, 1'b0, 1'b0); @(negedge clk); in_valid = 1'b0;
                    repeat (k - 1) @(negedge clk);
                    flush = 1'b1;
                    @(negedge clk);
                    flush = 1'b0;
                end else begin
                    offer(w, NF, 1'b1, 1'b0); @(negedge clk); in_valid = 1'b0;
                end
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            for (int i = 0; i < 400 && (sb.size() != 0 || coll); i++) @(negedge clk);
            chk($sformatf("L%0d_drain", g), sb.size() + int'(coll), 0);
            done1 = 1'b1;
            // Frame to be cut by asynchronous reset after 3 bits
            wait (go2);
            @(negedge clk);
            offer(8'hA5, 3, 1'b0, 1'b0); @(negedge clk); in_valid = 1'b0;
            repeat (2) @(negedge clk);
            req_rst = 1'b1;
        end
    end

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_outs("L0_reset", lane[0].in_ready, lane[0].shift_en, lane[0].data_out, lane[0].busy,
                 lane[0].frame_start, lane[0].frame_done, lane[0].bit_cnt);
        chk_outs("L1_reset", lane[1].in_ready, lane[1].shift_en, lane[1].data_out, lane[1].busy,
                 lane[1].frame_start, lane[1].frame_done, lane[1].bit_cnt);
        rst = 1'b1;
        #1;
        chk("L0_ready_before_edge", int'(lane[0].in_ready), 0);
        @(negedge clk);
        chk("L0_ready_after_release", int'(lane[0].in_ready), 1);
        chk("L1_ready_after_release", int'(lane[1].in_ready), 1);
        chk("L0_busy_after_release", int'(lane[0].busy), 0);
        chk("L1_busy_after_release", int'(lane[1].busy), 0);
        go = 1'b1;
        for (int i = 0; i < 30000 && !(lane[0].done1 && lane[1].done1); i++) @(negedge clk);
        chk("phase1_complete", int'(lane[0].done1 && lane[1].done1), 1);
        go2 = 1'b1;
        for (int i = 0; i < 5000 && !(lane[0].req_rst && lane[1].req_rst); i++) #1;
        chk("rst_phase_reached", int'(lane[0].req_rst && lane[1].req_rst), 1);
        #2 rst = 1'b0;
        #1;
        chk_outs("L0_async_rst", lane[0].in_ready, lane[0].shift_en, lane[0].data_out, lane[0].busy,
                 lane[0].frame_start, lane[0].frame_done, lane[0].bit_cnt);
        chk_outs("L1_async_rst", lane[1].in_ready, lane[1].shift_en, lane[1].data_out, lane[1].busy,
                 lane[1].frame_start, lane[1].frame_done, lane[1].bit_cnt);
        repeat (2) @(negedge clk);
        chk_outs("L0_rst_hold", lane[0].in_ready, lane[0].shift_en, lane[0].data_out, lane[0].busy,
                 lane[0].frame_start, lane[0].frame_done, lane[0].bit_cnt);
        rst = 1'b1;
        @(negedge clk);
        chk("L0_ready_after_rst2", int'(lane[0].in_ready), 1);
        chk("L1_ready_after_rst2", int'(lane[1].in_ready), 1);
        chk("L0_busy_after_rst2", int'(lane[0].busy), 0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
